// File: rtl/onehot_sequencer.sv
// Registered one-hot sequencer: holds a binary index and drives its one-hot decode.
// Optional wrap pulse output enabled by defining ONEHOT_SEQ_WRAP_EN.
module onehot_sequencer #(
    parameter int SEL_W = 3,
    parameter int LAST  = 2**SEL_W-1,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [SEL_W-1:0] code_i,
    input  logic             step_i,
    input  logic             dir_i,
    output logic [OUT_W-1:0] o,
    output logic [SEL_W-1:0] idx_o,
    output logic             valid_o,
    output logic             state_dbg
`ifdef ONEHOT_SEQ_WRAP_EN
    ,
    output logic             wrap_o
`endif
);

    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    localparam logic [SEL_W:0]   LAST_X = LAST[SEL_W:0];
    localparam logic [SEL_W:0]   ONE_X  = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] BIT0   = {{(OUT_W-1){1'b0}}, 1'b1};

    // Control inputs are plain level strobes sampled on every rising edge;
    // there is no handshake, each asserted input takes effect after that edge.
    logic             state, state_n;
    logic [SEL_W-1:0] idx_n, step_idx;
    logic [SEL_W:0]   idx_x, inc_x;
    logic [OUT_W-1:0] o_n;
    logic             do_step;

    // Index comparisons are made one bit wider so LAST = OUT_W-1 cannot overflow.
    assign idx_x   = {1'b0, idx_o};
    assign inc_x   = idx_x + ONE_X;
    assign do_step = step_i && !clear_i && !load_i && (state == ACTIVE);

    always_comb begin
        step_idx = idx_o;
        if (!dir_i) begin
            if (inc_x > LAST_X) step_idx = '0;
            else                step_idx = inc_x[SEL_W-1:0];
        end else begin
            if (idx_x == '0)         step_idx = LAST_X[SEL_W-1:0];
            else if (idx_x > LAST_X) step_idx = LAST_X[SEL_W-1:0];
            else                     step_idx = idx_o - ONE_X[SEL_W-1:0];
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx_o;
        if (clear_i) begin
            state_n = IDLE;
            idx_n   = '0;
        end else if (load_i) begin
            state_n = ACTIVE;
            idx_n   = code_i;
        end else if (do_step) begin
            idx_n   = step_idx;
        end
        o_n = (state_n == ACTIVE) ? (BIT0 << idx_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx_o <= '0;
            o     <= '0;
        end else begin
            state <= state_n;
            idx_o <= idx_n;
            o     <= o_n;
        end
    end

    // The FSM state register is the selection-active flag.
    assign valid_o   = (state == ACTIVE);
    assign state_dbg = state;

`ifdef ONEHOT_SEQ_WRAP_EN
    logic wrap_n;

    assign wrap_n = do_step && (dir_i ? (idx_x == '0) : (inc_x > LAST_X));

    always_ff @(posedge clk) begin
        if (rst) wrap_o <= 1'b0;
        else     wrap_o <= wrap_n;
    end
`endif

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer: one instance at LAST=7, one at LAST=5, shared stimulus.
module tb_onehot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_i = 1'b0;
    logic       load_i = 1'b0;
    logic [2:0] code_i = 3'd0;
    logic       step_i = 1'b0;
    logic       dir_i = 1'b0;

    logic [7:0] o, o5;
    logic [2:0] idx, idx5;
    logic       valid, valid5, st, st5;
`ifdef ONEHOT_SEQ_WRAP_EN
    logic       wrap, wrap5;
`endif

    int checks = 0;
    int failures = 0;

    onehot_sequencer #(.SEL_W(3), .LAST(7)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .load_i(load_i), .code_i(code_i),
        .step_i(step_i), .dir_i(dir_i), .o(o), .idx_o(idx), .valid_o(valid), .state_dbg(st)
`ifdef ONEHOT_SEQ_WRAP_EN
        , .wrap_o(wrap)
`endif
    );

    onehot_sequencer #(.SEL_W(3), .LAST(5)) dut5 (
        .clk(clk), .rst(rst), .clear_i(clear_i), .load_i(load_i), .code_i(code_i),
        .step_i(step_i), .dir_i(dir_i), .o(o5), .idx_o(idx5), .valid_o(valid5), .state_dbg(st5)
`ifdef ONEHOT_SEQ_WRAP_EN
        , .wrap_o(wrap5)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // popcount(o) must equal valid on every cycle, for both instances
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(o) != int'(valid) || $countones(o5) != int'(valid5) ||
                st !== valid || st5 !== valid5) begin
                failures++;
                $display("FAIL invariant t=%0t o=%h valid=%b st=%b o5=%h valid5=%b st5=%b",
                         $time, o, valid, st, o5, valid5, st5);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic clr, input logic ld, input logic [2:0] code,
                         input logic stp, input logic dir);
        clear_i = clr;
        load_i  = ld;
        code_i  = code;
        step_i  = stp;
        dir_i   = dir;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (o !== 8'h00 || idx !== 3'd0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset o=%h idx=%0d valid=%b want 00/0/0", o, idx, valid);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrap wrap=%b want 0", wrap);
        end
`endif
    endtask

    task automatic test_load();
        logic [7:0] exp_o;
        drive(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (o !== 8'h20 || idx !== 3'd5 || valid !== 1'b1) begin
            failures++;
            $display("FAIL load5 o=%h idx=%0d valid=%b want 20/5/1", o, idx, valid);
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 3'(c), 1'b0, 1'b0);
            tick();
            exp_o = 8'h01 << c;
            checks++;
            if (o !== exp_o || idx !== 3'(c) || o5 !== exp_o || idx5 !== 3'(c)) begin
                failures++;
                $display("FAIL sweep code=%0d o=%h o5=%h idx=%0d idx5=%0d want %h", c, o, o5, idx, idx5, exp_o);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_up();
        drive(1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (o !== 8'h01 || idx !== 3'd0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_up o=%h idx=%0d valid=%b want 01/0/1", o, idx, valid);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap_up_pulse wrap=%b want 1", wrap);
        end
`endif
        tick();
        checks++;
        if (o !== 8'h01 || idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_up_hold o=%h idx=%0d want 01/0", o, idx);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_up_pulse_end wrap=%b want 0", wrap);
        end
`endif
    endtask

    task automatic test_step_down();
        drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (idx5 !== 3'd5 || o5 !== 8'h20 || idx !== 3'd7 || o !== 8'h80) begin
            failures++;
            $display("FAIL down_wrap idx5=%0d o5=%h idx=%0d o=%h want 5/20 7/80", idx5, o5, idx, o);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap5 !== 1'b1 || wrap !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap_pulse wrap5=%b wrap=%b want 1/1", wrap5, wrap);
        end
`endif
        drive(1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (idx5 !== 3'd5 || o5 !== 8'h20 || idx !== 3'd6 || o !== 8'h40) begin
            failures++;
            $display("FAIL down_above_last idx5=%0d o5=%h idx=%0d o=%h want 5/20 6/40", idx5, o5, idx, o);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap5 !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_above_last_pulse wrap5=%b wrap=%b want 0/0", wrap5, wrap);
        end
`endif
    endtask

    task automatic test_idle_step();
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
            tick();
            checks++;
            if (o !== 8'h00 || valid !== 1'b0 || idx !== 3'd0 || o5 !== 8'h00 || idx5 !== 3'd0) begin
                failures++;
                $display("FAIL idle_step cyc=%0d o=%h valid=%b idx=%0d o5=%h idx5=%0d want 00/0/0",
                         k, o, valid, idx, o5, idx5);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        tick();
        checks++;
        if (valid !== 1'b0 || o !== 8'h00 || idx !== 3'd0) begin
            failures++;
            $display("FAIL clear_wins valid=%b o=%h idx=%0d want 0/00/0", valid, o, idx);
        end
        drive(1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (idx !== 3'd4 || o !== 8'h10 || valid !== 1'b1) begin
            failures++;
            $display("FAIL load_wins idx=%0d o=%h valid=%b want 4/10/1", idx, o, valid);
        end
`ifdef ONEHOT_SEQ_WRAP_EN
        checks++;
        if (wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_no_pulse wrap=%b want 0", wrap);
        end
`endif
        tick();
        tick();
        checks++;
        if (idx !== 3'd4 || o !== 8'h10 || valid !== 1'b1) begin
            failures++;
            $display("FAIL hold idx=%0d o=%h valid=%b want 4/10/1", idx, o, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_i  [3] = '{3'd4, 3'd5, 3'd6};
        logic [2:0] exp_i5 [3] = '{3'd4, 3'd5, 3'd0};
        drive(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
            tick();
            checks++;
            if (idx !== exp_i[k] || idx5 !== exp_i5[k]) begin
                failures++;
                $display("FAIL b2b step=%0d idx=%0d idx5=%0d want %0d/%0d", k, idx, idx5, exp_i[k], exp_i5[k]);
            end
`ifdef ONEHOT_SEQ_WRAP_EN
            checks++;
            if (wrap5 !== (k == 2) || wrap !== 1'b0) begin
                failures++;
                $display("FAIL b2b_pulse step=%0d wrap5=%b wrap=%b want %b/0", k, wrap5, wrap, k == 2);
            end
`endif
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap_up();
        test_step_down();
        test_idle_step();
        test_priority();
        test_back_to_back();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
